// File: rtl/alu_iter_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_exec
// Description : Single-issue ALU with a bit-serial shifter and valid/ready
//               handshakes on both the request and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  branch_taken_o,
    output logic                  illegal_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [4:0]            shift_cnt;
    logic                  shift_left;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_branch;
    logic                  is_shift;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] shift_next;

    assign shamt    = b_i[4:0];
    assign is_shift = (alu_operation_i == 4'b0100) || (alu_operation_i == 4'b0101);

    // Shift ops report a here; the nonzero-amount case goes through the serial shifter.
    always_comb begin
        alu_result = '0;
        alu_branch = 1'b0;
        case (alu_operation_i)
            4'b0000: alu_result = a_i + b_i;
            4'b0001: alu_result = a_i - b_i;
            4'b0010: alu_result = b_i;
            4'b0011: alu_result = a_i | b_i;
            4'b0100: alu_result = a_i;
            4'b0101: alu_result = a_i;
            4'b0110: alu_result = a_i & b_i;
            4'b0111: alu_result = a_i ^ b_i;
            4'b1000: begin
                alu_result = a_i - b_i;
                alu_branch = (a_i == b_i);
            end
            4'b1001: begin
                alu_result = a_i - b_i;
                alu_branch = (a_i != b_i);
            end
            4'b1010: begin
                alu_result = a_i - b_i;
                alu_branch = ($signed(a_i) < $signed(b_i));
            end
            4'b1011: alu_result = a_i + b_i;
            4'b1100: alu_result = a_i + b_i;
            4'b1101: alu_result = a_i + DATA_WIDTH'(4);
            4'b1110: alu_result = (a_i + b_i) & ~DATA_WIDTH'(1);
            default: alu_result = '0;
        endcase
    end

    assign shift_next = shift_left ? (shift_reg << 1) : (shift_reg >> 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            shift_reg      <= '0;
            shift_cnt      <= '0;
            shift_left     <= 1'b0;
            result_o       <= '0;
            zero_o         <= 1'b0;
            branch_taken_o <= 1'b0;
            illegal_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (is_shift && (shamt != 5'd0)) begin
                            shift_reg  <= a_i;
                            shift_cnt  <= shamt;
                            shift_left <= (alu_operation_i == 4'b0100);
                            state      <= SHIFT;
                        end else begin
                            result_o       <= alu_result;
                            zero_o         <= (alu_result == '0);
                            branch_taken_o <= alu_branch;
                            illegal_o      <= (alu_operation_i == 4'b1111);
                            state          <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    shift_cnt <= shift_cnt - 5'd1;
                    if (shift_cnt == 5'd1) begin
                        result_o       <= shift_next;
                        zero_o         <= (shift_next == '0);
                        branch_taken_o <= 1'b0;
                        illegal_o      <= 1'b0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o        = (state == IDLE);
    assign result_valid_o = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_iter_exec
// Description : Directed-vector bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        branch_taken_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    alu_iter_exec #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .alu_operation_i(alu_operation_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .zero_o         (zero_o),
        .branch_taken_o (branch_taken_o),
        .illegal_o      (illegal_o)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] n;
        n = b[4:0];
        case (op)
            4'd0, 4'd11, 4'd12: return a + b;
            4'd1, 4'd8, 4'd9, 4'd10: return a - b;
            4'd2:  return b;
            4'd3:  return a | b;
            4'd4:  return a << n;
            4'd5:  return a >> n;
            4'd6:  return a & b;
            4'd7:  return a ^ b;
            4'd13: return a + 32'd4;
            4'd14: return (a + b) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd8:  return a == b;
            4'd9:  return a != b;
            4'd10: return $signed(a) < $signed(b);
            default: return 1'b0;
        endcase
    endfunction

    // Transaction model: busy from acceptance until the result is taken.
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_res   = '0;
    logic        m_br    = 1'b0;
    logic        m_zero  = 1'b0;
    logic        m_ill   = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
            m_res = '0; m_br = 1'b0; m_zero = 1'b0; m_ill = 1'b0;
        end else if (m_valid) begin
            if (result_ready_i) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_valid = 1'b1;
        end else if (valid_i) begin
            m_res  = ref_result(alu_operation_i, a_i, b_i);
            m_br   = ref_branch(alu_operation_i, a_i, b_i);
            m_ill  = (alu_operation_i == 4'hF);
            m_zero = (m_res == 32'd0);
            m_busy = 1'b1;
            m_cnt  = (alu_operation_i == 4'd4 || alu_operation_i == 4'd5) ? int'(b_i[4:0]) : 0;
            if (m_cnt == 0) m_valid = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("model_ready", {31'd0, ready_o}, {31'd0, !m_busy});
        chk("model_rvalid", {31'd0, result_valid_o}, {31'd0, m_valid});
        if (m_valid) begin
            chk("model_result", result_o, m_res);
            chk("model_zero", {31'd0, zero_o}, {31'd0, m_zero});
            chk("model_branch", {31'd0, branch_taken_o}, {31'd0, m_br});
            chk("model_illegal", {31'd0, illegal_o}, {31'd0, m_ill});
        end
    end

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic br, input logic z, input logic il,
                         input int lat, input int hold);
        int n;
        int acc;
        @(negedge clk);
        valid_i = 1'b1; alu_operation_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        acc = cyc;
        valid_i = 1'b0; a_i = $urandom; b_i = $urandom; alu_operation_i = 4'($urandom);
        n = 0;
        while (result_valid_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        chk({tag, "_no_timeout"}, {31'd0, (n < 200)}, 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc + 1), 32'(lat));
        chk({tag, "_result"}, result_o, res);
        chk({tag, "_branch"}, {31'd0, branch_taken_o}, {31'd0, br});
        chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, z});
        chk({tag, "_illegal"}, {31'd0, illegal_o}, {31'd0, il});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            valid_i = 1'b1; alu_operation_i = 4'd0; a_i = $urandom; b_i = $urandom;
            @(posedge clk); #1;
            chk({tag, "_hold_ready"}, {31'd0, ready_o}, 32'd0);
            chk({tag, "_hold_result"}, result_o, res);
        end
        @(negedge clk);
        valid_i = 1'b0; result_ready_i = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_release_ready"}, {31'd0, ready_o}, 32'd1);
        chk({tag, "_release_rvalid"}, {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        result_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
        logic        z;
        int          lat;
    } vec_t;

    vec_t tbl [10] = '{
        '{4'h1, 32'd10,         32'd3,          32'd7,          1'b0, 1'b0, 1},
        '{4'h2, 32'd1,          32'h0000_ABCD,  32'h0000_ABCD,  1'b0, 1'b0, 1},
        '{4'h3, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0, 1},
        '{4'h5, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 5},
        '{4'h6, 32'h0000_FF00,  32'h0000_0FF0,  32'h0000_0F00,  1'b0, 1'b0, 1},
        '{4'h8, 32'd7,          32'd7,          32'd0,          1'b1, 1'b1, 1},
        '{4'hB, 32'd1,          32'd2,          32'd3,          1'b0, 1'b0, 1},
        '{4'hD, 32'h0000_0100,  32'h1234_5678,  32'h0000_0104,  1'b0, 1'b0, 1},
        '{4'h4, 32'd3,          32'h0000_0024,  32'h0000_0030,  1'b0, 1'b0, 5},
        '{4'h9, 32'd1,          32'd2,          32'hFFFF_FFFF,  1'b1, 1'b0, 1}
    };

    initial begin
        reset = 1'b0; valid_i = 1'b0; result_ready_i = 1'b0;
        alu_operation_i = 4'd0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result_o, 32'd0);
        chk("reset_rvalid", {31'd0, result_valid_o}, 32'd0);
        chk("reset_zero", {31'd0, zero_o}, 32'd0);
        chk("reset_branch", {31'd0, branch_taken_o}, 32'd0);
        chk("reset_illegal", {31'd0, illegal_o}, 32'd0);
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        // A request held during reset must not be accepted.
        @(negedge clk);
        valid_i = 1'b1; alu_operation_i = 4'd0; a_i = 32'd1; b_i = 32'd1;
        @(posedge clk); #1;
        chk("reset_no_accept", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        valid_i = 1'b0; reset = 1'b1;

        do_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1,  32'd0,         1'b0, 1'b1, 1'b0, 1, 0);
        do_op("sll31",    4'h4, 32'd1,         32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32, 0);
        do_op("sll0",     4'h4, 32'd1,         32'd0,  32'd1,         1'b0, 1'b0, 1'b0, 1, 0);
        do_op("blt",      4'hA, 32'hFFFF_FFFE, 32'd3,  32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0, 1, 0);
        do_op("bne_eq",   4'h9, 32'd5,         32'd5,  32'd0,         1'b0, 1'b1, 1'b0, 1, 0);
        do_op("xor_bp",   4'h7, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1, 5);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                  tbl[i].br, tbl[i].z, 1'b0, tbl[i].lat, 0);
        end

        // Abandon a long logical right shift partway through.
        @(negedge clk);
        valid_i = 1'b1; alu_operation_i = 4'h5; a_i = 32'h8000_0000; b_i = 32'd16;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midshift_rvalid", {31'd0, result_valid_o}, 32'd0);
        chk("midshift_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("midshift_no_result", {31'd0, result_valid_o}, 32'd0);

        do_op("add_after_rst", 4'h0, 32'd2,      32'd3,      32'd5,      1'b0, 1'b0, 1'b0, 1, 0);
        do_op("illegal",       4'hF, 32'h1234,   32'h5678,   32'd0,      1'b0, 1'b1, 1'b1, 1, 0);
        do_op("jalr",          4'hE, 32'h1001,   32'h0002,   32'h1002,   1'b0, 1'b0, 1'b0, 1, 0);

        repeat (3) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
